// File: rtl/hack_pkg.sv
// Shared constants for the instruction fetch path: address width, state encoding, jump-field bit positions.
// Pure definitions; no logic, so it adds no latency and has no flow control.
package hack_pkg;

   localparam int ADDR_W_DEF   = 15;
   localparam int WAIT_MAX_DEF = 15;

   // Bit positions inside a 16-bit instruction word
   localparam int C_BIT = 15;
   localparam int J_LT  = 2;
   localparam int J_EQ  = 1;
   localparam int J_GT  = 0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      EXEC   = 3'd2,
      UPDATE = 3'd3,
      HALT   = 3'd4
   } state_t;

endpackage

// File: rtl/jump_cond.sv
// Jump decision from the C-instruction jump field and the ALU flags.
// Purely combinational (zero latency); it has no handshake of its own.
module jump_cond
   import hack_pkg::*;
(
   input  logic       c_bit,
   input  logic [2:0] jbits,
   input  logic       zr,
   input  logic       ng,
   output logic       taken
);

   // A-instructions (c_bit=0) never jump
   assign taken = c_bit & ((jbits[J_LT] & ng) |
                           (jbits[J_EQ] & zr) |
                           (jbits[J_GT] & ~ng & ~zr));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute/update sequencer: 3 cycles per instruction, stalls in FETCH on rom_valid and in EXEC on exec_ready.
// A FETCH stall of WAIT_MAX cycles is fatal (fetch_err, HALT); HALT_DETECT_EN adds halting on a jump-to-self.
module fetch_sequencer
   import hack_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int WAIT_MAX = WAIT_MAX_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       rom_data,
   input  logic              rom_valid,
   output logic              rom_req,
   input  logic              exec_ready,
   input  logic              alu_zr,
   input  logic              alu_ng,
   input  logic [ADDR_W-1:0] a_reg,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic              pc_inc,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_in,
   output logic [15:0]       instr,
   output logic              instr_valid,
   output logic              halted,
   output logic              fetch_err
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  wait_cnt;
   logic              taken_q;
   logic [ADDR_W-1:0] target_q;
   logic              jump_now;
   logic              halt_hit;
   logic              wait_expired;

   jump_cond u_jump_cond (
      .c_bit (instr[C_BIT]),
      .jbits (instr[J_LT:J_GT]),
      .zr    (alu_zr),
      .ng    (alu_ng),
      .taken (jump_now)
   );

   // This cycle is the WAIT_MAX-th consecutive FETCH cycle without data
   assign wait_expired = (wait_cnt >= CNT_W'(WAIT_MAX - 1));

`ifdef HALT_DETECT_EN
   assign halt_hit = jump_now && (instr[J_LT:J_GT] == 3'b111) && (a_reg == pc_cur);
`else
   logic unused_pc_cur;
   assign halt_hit      = 1'b0;
   assign unused_pc_cur = ^pc_cur;
`endif

   always_comb begin
      state_nxt   = state;
      rom_req     = 1'b0;
      instr_valid = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      pc_in       = '0;
      halted      = 1'b0;
      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            rom_req = 1'b1;
            if (rom_valid)
               state_nxt = EXEC;
            else if (wait_expired)
               state_nxt = HALT;
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (exec_ready)
               state_nxt = halt_hit ? HALT : UPDATE;
         end
         UPDATE: begin
            pc_load   = taken_q;
            pc_inc    = ~taken_q;
            pc_in     = taken_q ? target_q : '0;
            state_nxt = FETCH;
         end
         HALT: halted = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr     <= '0;
         wait_cnt  <= '0;
         taken_q   <= 1'b0;
         target_q  <= '0;
         fetch_err <= 1'b0;
      end else begin
         // Holding the count at zero outside FETCH clears it on every FETCH entry
         if (state != FETCH)
            wait_cnt <= '0;
         else if (!rom_valid && (wait_cnt != CNT_W'(WAIT_MAX)))
            wait_cnt <= wait_cnt + CNT_W'(1);

         if (state == FETCH && rom_valid)
            instr <= rom_data;

         if (state == EXEC && exec_ready) begin
            taken_q  <= jump_now;
            target_q <= a_reg;
         end

         if (state == FETCH && !rom_valid && wait_expired)
            fetch_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected pc pulses are queued as each instruction is driven
// and popped by a negedge monitor whenever the sequencer pulses pc_inc/pc_load.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst;
   logic [15:0] rom_data;
   logic        rom_valid;
   logic        rom_req;
   logic        exec_ready;
   logic        alu_zr;
   logic        alu_ng;
   logic [14:0] a_reg;
   logic [14:0] pc_cur;
   logic        pc_inc;
   logic        pc_load;
   logic [14:0] pc_in;
   logic [15:0] instr;
   logic        instr_valid;
   logic        halted;
   logic        fetch_err;

   typedef struct packed {
      logic        load;
      logic        inc;
      logic [14:0] pcin;
   } pulse_t;

   pulse_t sb_q[$];
   int     errors = 0;
   int     checks = 0;
   int     pulses = 0;

   fetch_sequencer #(.ADDR_W(15), .WAIT_MAX(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .rom_data    (rom_data),
      .rom_valid   (rom_valid),
      .rom_req     (rom_req),
      .exec_ready  (exec_ready),
      .alu_zr      (alu_zr),
      .alu_ng      (alu_ng),
      .a_reg       (a_reg),
      .pc_cur      (pc_cur),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .pc_in       (pc_in),
      .instr       (instr),
      .instr_valid (instr_valid),
      .halted      (halted),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: every pc pulse must match the oldest queued expectation
   always @(negedge clk) begin
      pulse_t e;
      pulse_t got;
      got = '{load: pc_load, inc: pc_inc, pcin: pc_in};
      check("pc_exclusive", 32'(pc_inc & pc_load), 32'd0);
      if (!pc_load)
         check("pc_in_zero", 32'(pc_in), 32'd0);
      if (pc_inc || pc_load) begin
         pulses++;
         if (sb_q.size() == 0)
            check("unexpected_pulse", 32'(got), 32'd0);
         else begin
            e = sb_q.pop_front();
            check("pc_pulse", 32'(got), 32'(e));
         end
      end
   end

   function automatic pulse_t exp_pulse(input logic load, input logic [14:0] a);
      pulse_t p;
      p.load = load;
      p.inc  = ~load;
      p.pcin = load ? a : 15'h0;
      return p;
   endfunction

   // Called at a negedge while the sequencer sits in FETCH; returns at the next FETCH negedge
   task automatic do_instr(input string tag, input logic [15:0] d, input logic zr, input logic ng,
                           input logic [14:0] a, input logic exp_load, input int fstall, input int estall);
      int p0;
      check({tag, "_in_fetch"}, 32'(rom_req), 32'd1);
      sb_q.push_back(exp_pulse(exp_load, a));
      rom_data = d;
      alu_zr   = zr;
      alu_ng   = ng;
      a_reg    = a;
      for (int i = 0; i < fstall; i++) begin
         rom_valid  = 1'b0;
         exec_ready = 1'b1;
         @(negedge clk);
      end
      rom_valid  = 1'b1;
      exec_ready = 1'b0;
      @(negedge clk);
      check({tag, "_instr_valid"}, 32'(instr_valid), 32'd1);
      check({tag, "_instr"}, 32'(instr), 32'(d));
      rom_data = ~d;
      for (int i = 0; i < estall; i++) begin
         exec_ready = 1'b0;
         @(negedge clk);
      end
      check({tag, "_exec_hold"}, 32'(instr_valid), 32'd1);
      p0 = pulses;
      exec_ready = 1'b1;
      @(negedge clk);
      a_reg = ~a;
      @(negedge clk);
      check({tag, "_one_pulse"}, 32'(pulses), 32'(p0 + 1));
      check({tag, "_instr_kept"}, 32'(instr), 32'(d));
      rom_valid  = 1'b0;
      exec_ready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rom_req"}, 32'(rom_req), 32'd0);
      check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_pc_inc"}, 32'(pc_inc), 32'd0);
      check({tag, "_pc_load"}, 32'(pc_load), 32'd0);
      check({tag, "_pc_in"}, 32'(pc_in), 32'd0);
      check({tag, "_instr"}, 32'(instr), 32'd0);
      check({tag, "_halted"}, 32'(halted), 32'd0);
      check({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      rom_data   = 16'h0005;
      rom_valid  = 1'b1;
      exec_ready = 1'b1;
      alu_zr     = 1'b0;
      alu_ng     = 1'b0;
      a_reg      = 15'h0;
      pc_cur     = 15'h0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");

      // Back-to-back A-instructions: FETCH, EXEC, UPDATE(pc_inc) every 3 cycles
      sb_q.push_back(exp_pulse(1'b0, 15'h0));
      sb_q.push_back(exp_pulse(1'b0, 15'h0));
      rst = 1'b0;
      check("idle_rom_req", 32'(rom_req), 32'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("tp_rom_req", 32'(rom_req), 32'((k % 3) == 0));
         check("tp_instr_valid", 32'(instr_valid), 32'((k % 3) == 1));
         check("tp_pc_inc", 32'(pc_inc), 32'((k % 3) == 2));
      end
      check("tp_instr", 32'(instr), 32'h0005);
      rom_valid  = 1'b0;
      exec_ready = 1'b0;
      @(negedge clk);

      do_instr("jeq_taken",  16'hE302, 1'b1, 1'b0, 15'h2bcd, 1'b1, 0, 0);
      do_instr("jeq_not",    16'hE302, 1'b0, 1'b0, 15'h2bcd, 1'b0, 0, 0);
      do_instr("jlt_taken",  16'hE304, 1'b0, 1'b1, 15'h1234, 1'b1, 2, 1);
      do_instr("jlt_not",    16'hE304, 1'b0, 1'b0, 15'h1234, 1'b0, 0, 0);
      do_instr("jgt_taken",  16'hE301, 1'b0, 1'b0, 15'h7fff, 1'b1, 0, 2);
      do_instr("jgt_not",    16'hE301, 1'b1, 1'b0, 15'h7fff, 1'b0, 0, 0);
      do_instr("a_instr",    16'h7fff, 1'b1, 1'b1, 15'h0abc, 1'b0, 0, 0);
      do_instr("jmp_stall",  16'hE307, 1'b0, 1'b1, 15'h0042, 1'b1, 14, 3);
      check("stall14_no_err", 32'(fetch_err), 32'd0);

      pc_cur = 15'h0011;
      do_instr("jmp_other",  16'hEA87, 1'b0, 1'b0, 15'h0010, 1'b1, 0, 0);
      pc_cur = 15'h0010;
`ifdef HALT_DETECT_EN
      rom_data  = 16'hEA87;
      a_reg     = 15'h0010;
      rom_valid = 1'b1;
      @(negedge clk);
      rom_valid  = 1'b0;
      exec_ready = 1'b1;
      @(negedge clk);
      check("hd_halted", 32'(halted), 32'd1);
      check("hd_pc_load", 32'(pc_load), 32'd0);
      check("hd_rom_req", 32'(rom_req), 32'd0);
      rom_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("hd_halted_hold", 32'(halted), 32'd1);
      check("hd_fetch_err", 32'(fetch_err), 32'd0);
      rom_valid  = 1'b0;
      exec_ready = 1'b0;
`else
      do_instr("jmp_self",   16'hEA87, 1'b0, 1'b0, 15'h0010, 1'b1, 0, 0);
      check("self_not_halted", 32'(halted), 32'd0);
`endif

      // Fresh start, then reset asserted while an UPDATE pulse is live
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst2_fetch", 32'(rom_req), 32'd1);
      sb_q.push_back(exp_pulse(1'b1, 15'h2bcd));
      rom_data  = 16'hE302;
      alu_zr    = 1'b1;
      alu_ng    = 1'b0;
      a_reg     = 15'h2bcd;
      rom_valid = 1'b1;
      @(negedge clk);
      rom_valid  = 1'b0;
      exec_ready = 1'b1;
      @(negedge clk);
      check("mid_upd_load", 32'(pc_load), 32'd1);
      #1 rst = 1'b1;
      #1;
      check_all_zero("mid_upd_rst");
      exec_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("post_rst_idle", 32'(rom_req), 32'd0);
      @(negedge clk);
      check("post_rst_fetch", 32'(rom_req), 32'd1);
      check("post_rst_instr", 32'(instr), 32'd0);

      // FETCH starved of rom_valid: 14 cycles tolerated, the 15th is fatal
      repeat (14) @(negedge clk);
      check("to14_err", 32'(fetch_err), 32'd0);
      check("to14_rom_req", 32'(rom_req), 32'd1);
      @(negedge clk);
      check("to15_err", 32'(fetch_err), 32'd1);
      check("to15_halted", 32'(halted), 32'd1);
      check("to15_rom_req", 32'(rom_req), 32'd0);
      rom_valid  = 1'b1;
      exec_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("halt_rom_req", 32'(rom_req), 32'd0);
      check("halt_instr_valid", 32'(instr_valid), 32'd0);
      check("halt_sticky", 32'(halted), 32'd1);
      check("err_sticky", 32'(fetch_err), 32'd1);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, instruction-address width (matches program counter).
REQ-002 SHALL have parameter WAIT_MAX, default 15, maximum FETCH cycles without rom_valid before fault.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rom_data  in  16  instruction word from ROM.
REQ-006 SHALL have port rom_valid  in  1  rom_data valid; sampled only in FETCH.
REQ-007 SHALL have port rom_req  out  1  fetch request to ROM.
REQ-008 SHALL have port exec_ready  in  1  datapath finished current instruction; sampled only in EXEC.
REQ-009 SHALL have port alu_zr  in  1  ALU output zero.
REQ-010 SHALL have port alu_ng  in  1  ALU output negative.
REQ-011 SHALL have port a_reg  in  ADDR_W  A register low bits, jump target.
REQ-012 SHALL have port pc_cur  in  ADDR_W  current program-counter output.
REQ-013 SHALL have port pc_inc  out  1  drives program counter inc.
REQ-014 SHALL have port pc_load  out  1  drives program counter load.
REQ-015 SHALL have port pc_in  out  ADDR_W  drives program counter in.
REQ-016 SHALL have ports instr  out  16 and instr_valid  out  1: latched instruction and its valid flag.
REQ-017 SHALL have ports halted  out  1 and fetch_err  out  1, both sticky until reset.

Function
REQ-018 SHALL implement states IDLE, FETCH, EXEC, UPDATE, HALT.
REQ-019 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-020 FETCH SHALL assert rom_req; on rom_valid=1 at an edge, instr <= rom_data and next state is EXEC.
REQ-021 EXEC SHALL assert instr_valid; on exec_ready=1 at an edge, alu_zr, alu_ng and a_reg are sampled, the jump decision registered, next state UPDATE.
REQ-022 Jump taken SHALL equal instr[15] & ((instr[2]&ng) | (instr[1]&zr) | (instr[0]&~ng&~zr)); A-instructions (instr[15]=0) never jump.
REQ-023 UPDATE SHALL last one cycle with pc_load=1, pc_in=sampled a_reg if taken, else pc_inc=1; next state FETCH.
REQ-024 pc_load and pc_inc SHALL be mutually exclusive and high only in UPDATE; pc_in SHALL be 0 whenever pc_load=0.
REQ-025 Minimum throughput SHALL be 3 cycles per instruction (FETCH, EXEC, UPDATE) with rom_valid and exec_ready held high.
REQ-026 A wait counter SHALL count consecutive FETCH cycles with rom_valid=0; reaching WAIT_MAX SHALL set fetch_err, go to HALT, and issue no pc pulse.
REQ-027 The wait counter SHALL clear on every FETCH entry and saturate, never wrap.
REQ-028 HALT SHALL be terminal until reset: rom_req, instr_valid, pc_inc, pc_load all 0; halted=1.
REQ-029 rom_valid outside FETCH and exec_ready outside EXEC SHALL be ignored.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, all outputs 0, instr 0, wait counter 0, halted 0, fetch_err 0.
REQ-031 Reset mid-UPDATE SHALL suppress the pc pulse in the same cycle; no partial instruction is retried after release.

Configuration
REQ-032 Macro HALT_DETECT_EN defined: a taken jump with instr[2:0]=3'b111 and sampled a_reg == pc_cur SHALL go EXEC -> HALT with halted=1 and no pc_load pulse.
REQ-033 Macro HALT_DETECT_EN undefined: such a jump SHALL be an ordinary taken jump; halted is driven only by fetch_err.

Structure
REQ-034 Shared package hack_pkg SHALL hold ADDR_W default, state encoding, and jump-bit index constants (J_LT=2, J_EQ=1, J_GT=0, C_BIT=15).
REQ-035 Jump condition SHALL be a separate combinational sub-module jump_cond (instr[15], instr[2:0], zr, ng -> taken).

Verification
REQ-036 rst pulse, rom_valid=1, exec_ready=1, rom_data=16'h0005 -> IDLE, FETCH, EXEC, UPDATE with pc_inc=1 for one cycle, repeating every 3 cycles.
REQ-037 rom_data=16'hE302 (JEQ), zr=1, a_reg=15'h2bcd -> pc_load=1, pc_in=15'h2bcd for one cycle; with zr=0 -> pc_inc=1.
REQ-038 rom_data=16'hE304 (JLT), ng=1, zr=0 -> pc_load; ng=0 -> pc_inc; rom_data=16'hE301 (JGT), ng=0, zr=0 -> pc_load.
REQ-039 rom_valid held 0 in FETCH for 15 cycles -> fetch_err=1, halted=1, no further rom_req or pc pulses.
REQ-040 HALT_DETECT_EN defined, rom_data=16'hEA87, a_reg=pc_cur=15'h0010 -> halted=1, pc_load stays 0; undefined -> pc_load=1, pc_in=15'h0010.
REQ-041 rst asserted during UPDATE -> pc_inc and pc_load fall to 0 immediately; after release, IDLE then FETCH.
